// File: rtl/quiz_lock_ctrl.sv
// Quiz lockout sequencer: synchronises the encoder and host buttons, runs the arm/lock/timeout FSM,
// counts the answer time down and time-multiplexes contestant and timer digits to the 7-segment decoder.
module quiz_lock_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int SCAN_DIV   = 50000,
    parameter int ANSWER_SEC = 9,
    parameter int BUZZ_CYC   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_n,
    input  logic       clear_n,
    input  logic       enc_gs_n,
    input  logic [3:0] enc_code,
    output logic       lock_valid,
    output logic [3:0] lock_code,
    output logic       foul,
    output logic       timeout,
    output logic [2:0] state_o,
    output logic [3:0] bcd_out,
    output logic [3:0] dig_en_n,
    output logic       buzz
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(BUZZ_CYC + 1);
    localparam logic [6:0]    TIMER_INIT = 7'(ANSWER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BUZZ_LOAD  = BW'(BUZZ_CYC);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_LOCKED  = 3'd2,
        S_TIMEOUT = 3'd3,
        S_FOUL    = 3'd4
    } state_t;

    // Active-low controls idle high, so their synchronisers reset to 1.
    logic [2:0] ctl_raw;
    logic [2:0] ctl_sync;
    assign ctl_raw = {start_n, clear_n, enc_gs_n};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ctl_sync
            logic s1_reg;
            logic s2_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_reg <= 1'b1;
                    s2_reg <= 1'b1;
                end else begin
                    s1_reg <= ctl_raw[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign ctl_sync[gi] = s2_reg;
        end
    endgenerate

    logic [3:0] code_s1_reg;
    logic [3:0] code_s2_reg;
    logic       start_prev_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_s1_reg    <= 4'd0;
            code_s2_reg    <= 4'd0;
            start_prev_reg <= 1'b1;
        end else begin
            code_s1_reg    <= enc_code;
            code_s2_reg    <= code_s1_reg;
            start_prev_reg <= ctl_sync[2];
        end
    end

    logic start_pulse;
    logic clear_req;
    logic press;
    assign start_pulse = start_prev_reg & ~ctl_sync[2];
    assign clear_req   = ~ctl_sync[1];
    assign press       = ~ctl_sync[0];

    state_t        state_reg;
    logic          lock_valid_reg;
    logic [3:0]    lock_code_reg;
    logic          foul_reg;
    logic          timeout_reg;
    logic [6:0]    timer_reg;
    logic [PW-1:0] presc_reg;
    logic [BW-1:0] buzz_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            lock_valid_reg <= 1'b0;
            lock_code_reg  <= 4'd0;
            foul_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            timer_reg      <= TIMER_INIT;
            presc_reg      <= '0;
            buzz_cnt_reg   <= '0;
        end else begin
            if (buzz_cnt_reg != '0) begin
                buzz_cnt_reg <= buzz_cnt_reg - BW'(1);
            end
            if (clear_req) begin
                state_reg      <= S_IDLE;
                lock_valid_reg <= 1'b0;
                foul_reg       <= 1'b0;
                timeout_reg    <= 1'b0;
                timer_reg      <= TIMER_INIT;
                presc_reg      <= '0;
                buzz_cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        timer_reg <= TIMER_INIT;
                        // A key already down when the host starts is a false start.
                        if (press) begin
                            state_reg      <= S_FOUL;
                            lock_valid_reg <= 1'b1;
                            foul_reg       <= 1'b1;
                            lock_code_reg  <= code_s2_reg;
                            buzz_cnt_reg   <= BUZZ_LOAD;
                        end else if (start_pulse) begin
                            state_reg <= S_ARMED;
                            presc_reg <= '0;
                        end
                    end
                    S_ARMED: begin
                        if (press) begin
                            state_reg      <= S_LOCKED;
                            lock_valid_reg <= 1'b1;
                            lock_code_reg  <= code_s2_reg;
                            buzz_cnt_reg   <= BUZZ_LOAD;
                        end else if (presc_reg == PRESC_LAST) begin
                            presc_reg <= '0;
                            if (timer_reg != 7'd0) begin
                                timer_reg <= timer_reg - 7'd1;
                            end
                            if (timer_reg <= 7'd1) begin
                                state_reg    <= S_TIMEOUT;
                                timeout_reg  <= 1'b1;
                                buzz_cnt_reg <= BUZZ_LOAD;
                            end
                        end else begin
                            presc_reg <= presc_reg + PW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Display digits, built from the current register values.
    logic [4:0] contestant;
    logic [3:0] digit_val [4];
    assign contestant = 5'(lock_code_reg) + 5'd1;

    always_comb begin
        digit_val[0] = 4'hF;
        digit_val[1] = 4'hF;
        if (lock_valid_reg) begin
            digit_val[0] = (contestant >= 5'd10) ? 4'd1 : 4'hF;
            digit_val[1] = (contestant >= 5'd10) ? 4'(contestant - 5'd10) : contestant[3:0];
        end
        digit_val[2] = (timer_reg >= 7'd10) ? 4'(timer_reg / 7'd10) : 4'hF;
        digit_val[3] = 4'(timer_reg % 7'd10);
    end

    logic [SW-1:0] scan_cnt_reg;
    logic [1:0]    dig_ptr_reg;
    logic [1:0]    dig_ptr_next;
    logic [3:0]    dig_en_n_reg;
    logic [3:0]    bcd_out_reg;

    assign dig_ptr_next = (scan_cnt_reg == SCAN_LAST) ? dig_ptr_reg + 2'd1 : dig_ptr_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_reg <= '0;
            dig_ptr_reg  <= 2'd0;
            dig_en_n_reg <= 4'b1110;
            bcd_out_reg  <= 4'hF;
        end else begin
            scan_cnt_reg <= (scan_cnt_reg == SCAN_LAST) ? '0 : scan_cnt_reg + SW'(1);
            dig_ptr_reg  <= dig_ptr_next;
            dig_en_n_reg <= ~(4'b0001 << dig_ptr_next);
            bcd_out_reg  <= digit_val[dig_ptr_next];
        end
    end

    assign lock_valid = lock_valid_reg;
    assign lock_code  = lock_code_reg;
    assign foul       = foul_reg;
    assign timeout    = timeout_reg;
    assign state_o    = state_reg;
    assign bcd_out    = bcd_out_reg;
    assign dig_en_n   = dig_en_n_reg;
    assign buzz       = (buzz_cnt_reg != '0);

endmodule

// File: tb/tb_quiz_lock_ctrl.sv
// Bench for quiz_lock_ctrl: directed test-plan scenarios plus random button traffic, checked against a
// behavioural model; state changes go through a scoreboard queue, display/buzz are checked every cycle.
module tb_quiz_lock_ctrl;

    localparam int TD = 10;
    localparam int SD = 4;
    localparam int AS = 3;
    localparam int BC = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_n = 1'b1;
    logic       clear_n = 1'b1;
    logic       enc_gs_n = 1'b1;
    logic [3:0] enc_code = 4'd0;
    logic       lock_valid;
    logic [3:0] lock_code;
    logic       foul;
    logic       timeout;
    logic [2:0] state_o;
    logic [3:0] bcd_out;
    logic [3:0] dig_en_n;
    logic       buzz;

    quiz_lock_ctrl #(
        .TICK_DIV  (TD),
        .SCAN_DIV  (SD),
        .ANSWER_SEC(AS),
        .BUZZ_CYC  (BC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_n   (start_n),
        .clear_n   (clear_n),
        .enc_gs_n  (enc_gs_n),
        .enc_code  (enc_code),
        .lock_valid(lock_valid),
        .lock_code (lock_code),
        .foul      (foul),
        .timeout   (timeout),
        .state_o   (state_o),
        .bcd_out   (bcd_out),
        .dig_en_n  (dig_en_n),
        .buzz      (buzz)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: states 0 idle,1 armed,2 locked,3 timeout,4 foul.
    typedef struct {
        int st;
        int code;
    } evt_t;
    evt_t exp_q[$];

    bit model_valid = 0;
    int m_st = 0, m_code = 0, m_tmr = AS, m_presc = 0, m_buzz = 0;
    int m_scan = 0, m_ptr = 0, m_bcd = 15;
    int gs_d0 = 1, gs_d1 = 1, cd_d0 = 0, cd_d1 = 0;
    int st_d0 = 1, st_d1 = 1, st_prev = 1, cl_d0 = 1, cl_d1 = 1;

    function automatic int digit(input int p, input int lv, input int code, input int tmr);
        int n;
        n = code + 1;
        case (p)
            0: return (lv == 0) ? 15 : ((n >= 10) ? n / 10 : 15);
            1: return (lv == 0) ? 15 : n % 10;
            2: return (tmr >= 10) ? tmr / 10 : 15;
            default: return tmr % 10;
        endcase
    endfunction

    always @(posedge clk) begin : model
        int prev_st, old_lv, old_code, old_tmr;
        bit press, clr, start_p;
        prev_st = m_st;
        if (rst_n === 1'b0) begin
            m_st = 0; m_code = 0; m_tmr = AS; m_presc = 0; m_buzz = 0;
            m_scan = 0; m_ptr = 0; m_bcd = 15;
            gs_d0 = 1; gs_d1 = 1; cd_d0 = 0; cd_d1 = 0;
            st_d0 = 1; st_d1 = 1; st_prev = 1; cl_d0 = 1; cl_d1 = 1;
            if (model_valid && prev_st != 0) exp_q.push_back('{0, m_code});
            model_valid = 1;
        end else if (model_valid) begin
            old_lv   = (m_st == 2 || m_st == 4) ? 1 : 0;
            old_code = m_code;
            old_tmr  = m_tmr;
            press    = (gs_d1 == 0);
            clr      = (cl_d1 == 0);
            start_p  = (st_prev == 1 && st_d1 == 0);
            if (clr) begin
                m_st = 0; m_tmr = AS; m_presc = 0;
            end else if (m_st == 0) begin
                m_tmr = AS;
                if (press) begin m_st = 4; m_code = cd_d1; end
                else if (start_p) begin m_st = 1; m_presc = 0; end
            end else if (m_st == 1) begin
                if (press) begin
                    m_st = 2; m_code = cd_d1;
                end else begin
                    m_presc++;
                    if (m_presc == TD) begin
                        m_presc = 0;
                        m_tmr--;
                        if (m_tmr == 0) m_st = 3;
                    end
                end
            end
            if (clr) m_buzz = 0;
            else if (m_st != prev_st && m_st >= 2) m_buzz = BC;
            else if (m_buzz > 0) m_buzz--;
            m_scan++;
            if (m_scan == SD) begin
                m_scan = 0;
                m_ptr = (m_ptr + 1) % 4;
            end
            m_bcd = digit(m_ptr, old_lv, old_code, old_tmr);
            st_prev = st_d1; st_d1 = st_d0; st_d0 = int'(start_n);
            cl_d1 = cl_d0; cl_d0 = int'(clear_n);
            gs_d1 = gs_d0; gs_d0 = int'(enc_gs_n);
            cd_d1 = cd_d0; cd_d0 = int'(enc_code);
            if (m_st != prev_st) exp_q.push_back('{m_st, m_code});
        end
    end

    // Monitor: per-cycle output check plus scoreboard pop on each DUT state change.
    int prev_dut_st = 0;
    always @(negedge clk) begin
        evt_t e;
        if (model_valid) begin
            chk("state_o", int'(state_o), m_st);
            chk("lock_valid", int'(lock_valid), (m_st == 2 || m_st == 4) ? 1 : 0);
            chk("lock_code", int'(lock_code), m_code);
            chk("foul", int'(foul), (m_st == 4) ? 1 : 0);
            chk("timeout", int'(timeout), (m_st == 3) ? 1 : 0);
            chk("buzz", int'(buzz), (m_buzz > 0) ? 1 : 0);
            chk("dig_en_n", int'(dig_en_n), 15 & ~(1 << m_ptr));
            chk("bcd_out", int'(bcd_out), m_bcd);
            if (int'(state_o) != prev_dut_st) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_state", int'(state_o), prev_dut_st);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_state", int'(state_o), e.st);
                    chk("sb_code", int'(lock_code), e.code);
                end
                prev_dut_st = int'(state_o);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        start_n = 1'b0;
        cyc(3);
        start_n = 1'b1;
    endtask

    task automatic do_clear();
        clear_n = 1'b0;
        cyc(3);
        clear_n = 1'b1;
        cyc(3);
    endtask

    initial begin
        int r;
        cyc(1);
        chk("rst_dig_en_n", int'(dig_en_n), 14);
        chk("rst_bcd_out", int'(bcd_out), 15);
        cyc(2);
        rst_n = 1'b1;
        cyc(8);

        // Reset mid-ARMED with timer at 2.
        do_start();
        cyc(14);
        rst_n = 1'b0;
        cyc(1);
        chk("midrst_state", int'(state_o), 0);
        chk("midrst_dig_en_n", int'(dig_en_n), 14);
        chk("midrst_bcd", int'(bcd_out), 15);
        chk("midrst_buzz", int'(buzz), 0);
        rst_n = 1'b1;
        cyc(6);

        // Press after 12 cycles of ARMED -> LOCKED with contestant 12.
        do_start();
        cyc(9);
        enc_code = 4'd11;
        enc_gs_n = 1'b0;
        cyc(4);
        chk("lock_state", int'(state_o), 2);
        chk("lock_code11", int'(lock_code), 11);
        enc_gs_n = 1'b1;
        cyc(30);
        do_clear();

        // No press -> TIMEOUT; later presses ignored.
        do_start();
        cyc(40);
        chk("timeout_flag", int'(timeout), 1);
        enc_code = 4'd7;
        enc_gs_n = 1'b0;
        cyc(5);
        enc_gs_n = 1'b1;
        chk("timeout_hold", int'(state_o), 3);
        do_clear();

        // Press and start together in IDLE -> FOUL.
        enc_code = 4'd4;
        enc_gs_n = 1'b0;
        start_n = 1'b0;
        cyc(4);
        chk("foul_flag", int'(foul), 1);
        chk("foul_code", int'(lock_code), 4);
        start_n = 1'b1;
        enc_gs_n = 1'b1;
        cyc(20);
        do_clear();

        // Press synced in the same cycle as the final tick -> LOCKED wins.
        start_n = 1'b0;
        cyc(3);
        start_n = 1'b1;
        cyc(27);
        enc_code = 4'd9;
        enc_gs_n = 1'b0;
        cyc(4);
        chk("tie_state", int'(state_o), 2);
        chk("tie_timeout", int'(timeout), 0);
        enc_gs_n = 1'b1;
        cyc(20);
        do_clear();
        cyc(16);

        // Random traffic.
        repeat (250) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: begin
                    enc_code = 4'($urandom_range(0, 15));
                    enc_gs_n = 1'b0;
                    cyc($urandom_range(1, 6));
                    enc_gs_n = 1'b1;
                end
                4, 5: do_start();
                6: do_clear();
                7: cyc($urandom_range(1, 40));
                8: begin
                    if ($urandom_range(0, 3) == 0) begin
                        rst_n = 1'b0;
                        cyc($urandom_range(1, 2));
                        rst_n = 1'b1;
                    end else begin
                        cyc(2);
                    end
                end
                default: begin
                    clear_n = 1'b0;
                    enc_code = 4'($urandom_range(0, 15));
                    enc_gs_n = 1'b0;
                    cyc($urandom_range(1, 4));
                    clear_n = 1'b1;
                    enc_gs_n = 1'b1;
                end
            endcase
            cyc(1);
        end

        cyc(5);
        chk("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
